// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron accumulator stage.
// Optional feature: define NEURON_RELU_EN for ReLU activation (default: identity).
package neuron_pkg;

  localparam int PROD_W     = 16;
  localparam int ACC_W      = 24;
  localparam int OUT_W      = 8;
  localparam int FRAC_SHIFT = 8;
  localparam int MAX_TERMS  = 16;

  // One extra bit so the counter can hold MAX_TERMS itself.
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  // Output clamp bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_LO = ~OUT_HI;

  typedef enum logic [1:0] {ACCUM, BIAS, ACT, OUT} state_t;

  // Sign-magnitude product as delivered by the multiplier.
  typedef struct packed {
    logic              sign;
    logic [PROD_W-2:0] mag;
  } sm_prod_t;

  // Sign-extend a two's-complement PROD_W value to ACC_W.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] v);
    return {{(ACC_W - PROD_W){v[PROD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/neuron_accumulator_sm_to_twos.sv
// Combinational sign-magnitude to two's-complement converter.
// Negative zero maps to zero because negating a zero magnitude yields zero.
module sm_to_twos
  import neuron_pkg::*;
(
  input  sm_prod_t                 prod,
  output logic signed [ACC_W-1:0]  value
);

  logic [ACC_W-1:0] mag_ext;

  assign mag_ext = {{(ACC_W - PROD_W + 1){1'b0}}, prod.mag};
  assign value   = prod.sign ? -mag_ext : mag_ext;

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums a frame of sign-magnitude products, adds bias,
// rescales, activates/saturates and emits one output per frame.
// Optional feature: NEURON_RELU_EN selects ReLU activation; otherwise the
// activation is identity with a signed clamp.
module neuron_accumulator
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic [PROD_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_trunc
);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic [PROD_W-1:0]        bias_q;
  logic                     trunc_q;

  logic signed [ACC_W-1:0]  conv_val;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         act_data;
  logic                     act_sat;
  logic                     accept;
  logic                     frame_end;

  sm_to_twos u_conv (
    .prod  (sm_prod_t'(in_prod)),
    .value (conv_val)
  );

  assign accept    = in_valid && in_ready;
  assign frame_end = in_last || (cnt == CNT_W'(MAX_TERMS - 1));

  // acc is signed, so this floors toward -inf.
  assign shifted = acc >>> FRAC_SHIFT;

  // Clamp the rescaled sum into the signed output range, then apply activation.
  always_comb begin
    act_data = shifted[OUT_W-1:0];
    act_sat  = 1'b0;
    if (shifted > OUT_HI) begin
      act_data = OUT_HI[OUT_W-1:0];
      act_sat  = 1'b1;
    end else if (shifted < OUT_LO) begin
      act_data = OUT_LO[OUT_W-1:0];
      act_sat  = 1'b1;
    end
`ifdef NEURON_RELU_EN
    // Negative results are the normal ReLU zero, not a saturation event.
    if (shifted[ACC_W-1]) begin
      act_data = '0;
      act_sat  = 1'b0;
    end
`endif
  end

  // Frame sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      bias_q    <= '0;
      trunc_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc + conv_val;
            cnt <= cnt + 1'b1;
            // The bias belongs to the frame, so latch it with the first term.
            if (cnt == '0) bias_q <= bias;
            if (frame_end) begin
              trunc_q  <= !in_last;
              in_ready <= 1'b0;
              state    <= BIAS;
            end
          end
        end
        BIAS: begin
          acc   <= acc + sext_prod(bias_q);
          state <= ACT;
        end
        ACT: begin
          out_data  <= act_data;
          out_sat   <= act_sat;
          out_trunc <= trunc_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
            trunc_q   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator (honours NEURON_RELU_EN).
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_prod, bias;
  logic        out_valid, out_ready, out_sat, out_trunc;
  logic [7:0]  out_data;

  int vectors     = 0;
  int miscompares = 0;

  neuron_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, floor division by 2^8, clamp to int8.
  function automatic void model(input int prods[$], input int b,
                                output int d, output bit s);
    longint sum = 0;
    longint r;
    foreach (prods[i]) begin
      int mag = prods[i] & 'h7FFF;
      sum += ((prods[i] & 'h8000) != 0) ? -mag : mag;
    end
    sum += (b >= 32768) ? b - 65536 : b;
    r = sum / 256;
    if (sum < 0 && (sum % 256) != 0) r = r - 1;
    s = 1'b0;
    if (r > 127) begin r = 127; s = 1'b1; end
    else if (r < -128) begin r = -128; s = 1'b1; end
`ifdef NEURON_RELU_EN
    if (r < 0) begin r = 0; s = 1'b0; end
`endif
    d = int'(r) & 'hFF;
  endfunction

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  // Feed one frame, check latency, output, hold behaviour and return to ACCUM.
  task automatic run_frame(input string tag, input int prods[$], input int b,
                           input bit use_last, input int hold, input bit gaps);
    int  lat;
    int  ed;
    bit  es;
    logic [7:0] d0;
    for (int i = 0; i < prods.size(); i++) begin
      check({tag, " in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_prod  = 16'(prods[i]);
      in_last  = use_last && (i == prods.size() - 1);
      bias     = (i == 0) ? 16'(b) : 16'($urandom);
      tick;
      if (gaps && i < prods.size() - 1 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " in_ready_busy"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    if (!out_valid) begin
      do_reset;
      return;
    end
    model(prods, b, ed, es);
    check({tag, " data"},  out_data,  ed);
    check({tag, " sat"},   out_sat,   es);
    check({tag, " trunc"}, out_trunc, !use_last);
    d0 = out_data;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_prod  = 16'($urandom);
      tick;
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_data"},  out_data,  d0);
      check({tag, " hold_sat"},   out_sat,   es);
      check({tag, " hold_trunc"}, out_trunc, !use_last);
      check({tag, " hold_rdy"},   in_ready,  0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, " post_valid"}, out_valid, 0);
    check({tag, " post_ready"}, in_ready,  1);
  endtask

  initial begin
    int q[$];
    in_prod = '0; bias = '0;

    // Reset state.
    do_reset;
    check("rst out_valid", out_valid, 0);
    check("rst out_data",  out_data,  0);
    check("rst out_sat",   out_sat,   0);
    check("rst out_trunc", out_trunc, 0);
    check("rst in_ready",  in_ready,  1);

    // Two-term frame.
    q = '{'h0100, 'h0200};
    run_frame("t1", q, 0, 1'b1, 0, 1'b0);

    // Negative single term.
    q = '{'h8300};
    run_frame("t2", q, 0, 1'b1, 0, 1'b0);

    // Truncated saturating frame.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back('h7FFF);
    run_frame("t3", q, 0, 1'b0, 0, 1'b0);

    // Back-pressure for 5 cycles.
    q = '{'h1234, 'h8100, 'h0400};
    run_frame("t4", q, 'h0080, 1'b1, 5, 1'b0);

    // Reset mid-frame discards the partial sum.
    in_valid = 1'b1; in_last = 1'b0; in_prod = 16'h0500; bias = 16'h0000;
    tick; tick;
    in_valid = 1'b0;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t5 no_out", out_valid, 0);
    end
    q = '{'h0100};
    run_frame("t5", q, 0, 1'b1, 0, 1'b0);

    // Negative zero plus bias.
    q = '{'h8000};
    run_frame("t6", q, 'h0100, 1'b1, 0, 1'b0);

    // Last term arriving exactly at MAX_TERMS is not a truncation.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back('h0010);
    run_frame("t7", q, 'hFF00, 1'b1, 1, 1'b0);

    // Reset while holding an output drops it.
    in_valid = 1'b1; in_last = 1'b1; in_prod = 16'h0700; bias = 16'h0000;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    tick; tick;
    check("t8 pre_valid", out_valid, 1);
    do_reset;
    check("t8 rst_valid", out_valid, 0);
    check("t8 rst_ready", in_ready,  1);
    check("t8 rst_data",  out_data,  0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int  len = $urandom_range(1, 16);
      bit  ul  = (len < 16) ? 1'b1 : 1'($urandom);
      bit  big = 1'($urandom);
      q = {};
      for (int i = 0; i < len; i++) begin
        int mag = big ? $urandom_range(0, 32767)
                      : $urandom_range(0, 127) * $urandom_range(0, 127);
        q.push_back(($urandom_range(0, 1) << 15) | mag);
      end
      run_frame("rnd", q, $urandom_range(0, 65535), ul, $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
